// File: rtl/packet_buf_cntl.sv
// packet_buf_cntl: packet buffer controller between NUM_SRC packet producers and the
// downstream packet FIFO. Round-robin arbitrates writers into a single-port circular SRAM,
// drains stored packets to the FIFO when no write is eligible, tracks occupancy, and
// handles replay-iteration flush plus a terminal stall on the final replay iteration.
//
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_src_valid / i_src_packet     per-source packet valid / data (source i at [i*PACKET_W +: PACKET_W])
//   o_src_ready                    one-hot write grant (combinational)
//   i_replay_iter_flag, i_replay_iter  replay boundary pulse and current iteration
//   i_fifo_full                    downstream almost-full
//   i_sram_rdata                   SRAM read data, valid one cycle after o_sram_re_en
//   o_sram_wr_en, o_sram_re_en, o_sram_addr, o_sram_wdata  SRAM port
//   o_out_valid, o_out_packet      packet to FIFO
//   o_count, o_buf_full, o_buf_empty  occupancy
//   o_state                        FSM state (IDLE=0, STREAM=1, STALL=2)
module packet_buf_cntl #(
  parameter int unsigned PACKET_W  = 64,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned NUM_SRC   = 2,
  parameter int unsigned ITER_W    = 2,
  parameter int unsigned STOP_ITER = 3,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1,
  localparam int unsigned SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [NUM_SRC-1:0]          i_src_valid,
  input  logic [NUM_SRC*PACKET_W-1:0] i_src_packet,
  output logic [NUM_SRC-1:0]          o_src_ready,
  input  logic                        i_replay_iter_flag,
  input  logic [ITER_W-1:0]           i_replay_iter,
  input  logic                        i_fifo_full,
  input  logic [PACKET_W-1:0]         i_sram_rdata,
  output logic                        o_sram_wr_en,
  output logic                        o_sram_re_en,
  output logic [AW-1:0]               o_sram_addr,
  output logic [PACKET_W-1:0]         o_sram_wdata,
  output logic                        o_out_valid,
  output logic [PACKET_W-1:0]         o_out_packet,
  output logic [CW-1:0]               o_count,
  output logic                        o_buf_full,
  output logic                        o_buf_empty,
  output logic [1:0]                  o_state
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStream = 2'd1,
    StStall  = 2'd2
  } state_e;

  state_e              r_state, w_state_nxt;
  logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic [SW-1:0]       r_rr;
  logic                r_rd_pend;
  logic [PACKET_W-1:0] r_out_hold;

  logic                w_full, w_empty;
  logic                w_active, w_replay;
  logic                w_found;
  logic [SW-1:0]       w_win;
  logic [SW:0]         w_idx;
  logic [SW-1:0]       w_rr_nxt;
  logic                w_wr, w_rd;
  logic [PACKET_W-1:0] w_pkt;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  // A replay-flag cycle suppresses all grants and SRAM traffic.
  assign w_active = (r_state == StStream) && !i_replay_iter_flag;
  assign w_replay = (r_state == StStream) && i_replay_iter_flag;

  // Round-robin search starting at r_rr, wrapping modulo NUM_SRC.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_idx = {1'b0, r_rr} + (SW+1)'(k);
      if (w_idx >= (SW+1)'(NUM_SRC)) begin
        w_idx = w_idx - (SW+1)'(NUM_SRC);
      end
      if (!w_found && i_src_valid[w_idx[SW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[SW-1:0];
      end
    end
  end

  assign w_rr_nxt = (w_win == SW'(NUM_SRC - 1)) ? '0 : w_win + 1'b1;
  assign w_pkt    = i_src_packet[w_win*PACKET_W +: PACKET_W];

  // Write has priority; a read only goes out when no write is eligible.
  assign w_wr = w_active && w_found && !w_full;
  assign w_rd = w_active && !(w_found && !w_full) && !w_empty && !i_fifo_full;

  always_comb begin
    o_src_ready  = '0;
    o_sram_addr  = '0;
    o_sram_wdata = '0;
    if (w_wr) begin
      o_src_ready  = NUM_SRC'(1) << w_win;
      o_sram_addr  = r_wr_ptr;
      o_sram_wdata = w_pkt;
    end else if (w_rd) begin
      o_sram_addr  = r_rd_ptr;
    end
  end

  assign o_sram_wr_en = w_wr;
  assign o_sram_re_en = w_rd;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   w_state_nxt = StStream;
      StStream: begin
        if (i_replay_iter_flag) begin
          w_state_nxt = (i_replay_iter == ITER_W'(STOP_ITER)) ? StStall : StIdle;
        end
      end
      StStall:  w_state_nxt = StStall;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rr       <= '0;
      r_rd_pend  <= 1'b0;
      r_out_hold <= '0;
    end else begin
      r_state   <= w_state_nxt;
      // w_rd is never set in a replay cycle, so an in-flight read is not extended.
      r_rd_pend <= w_rd;
      if (r_rd_pend) begin
        r_out_hold <= i_sram_rdata;
      end
      if (w_replay) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_wr) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          r_count  <= r_count + 1'b1;
          r_rr     <= w_rr_nxt;
        end
        if (w_rd) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
          r_count  <= r_count - 1'b1;
        end
      end
    end
  end

  // SRAM data arrives the cycle after issue; pass it straight through while the read is
  // pending (one-cycle latency) and hold the last delivered packet otherwise.
  assign o_out_valid  = r_rd_pend;
  assign o_out_packet = r_rd_pend ? i_sram_rdata : r_out_hold;

  assign o_count     = r_count;
  assign o_buf_full  = w_full;
  assign o_buf_empty = w_empty;
  assign o_state     = r_state;

endmodule
